fetch_unit: RTL and testbench

- Holds the PC, instruction register (IR) and saved-PC (OldPC) for the multicycle 16-bit processor.
- Sits directly upstream of control_unit: feeds it Opcode, and consumes its IRWrite, PCWrite, isBranch and PCSrc strobes to sequence fetch, branch, jump and JR.
- Also provides the decoded IR fields, the sign-extended immediate, a sticky misalignment flag and a retired-instruction counter.

---
 rtl/fetch_unit.sv | 147 ++++++++++++++
 tb/tb_fetch_unit.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: PC, instruction register and saved-PC for the multicycle
// 16-bit processor. Sequences fetch, branch, jump and JR from the
// control_unit strobes and presents the decoded IR fields downstream.
module fetch_unit #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter int          JMP_SHIFT = 1
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        IRWrite,
    input  logic        PCWrite,
    input  logic        isBranch,
    input  logic [1:0]  PCSrc,
    input  logic [15:0] MemData,
    input  logic [15:0] ALUResult,
    input  logic [15:0] ALUOut,
    input  logic [15:0] RegData,
    input  logic        Zero,
    output logic [5:0]  Opcode,
    output logic [15:0] PC,
    output logic [15:0] OldPC,
    output logic [15:0] IR,
    output logic [3:0]  Rd,
    output logic [3:0]  Rs,
    output logic [3:0]  Rt,
    output logic [15:0] Imm,
    output logic        BranchTaken,
    output logic        PCMisalign,
    output logic [15:0] InstrCount
);

    // Branch encodings carried in IR[13:12]
    localparam logic [1:0] BR_EQ = 2'b01;
    localparam logic [1:0] BR_NE = 2'b10;

    logic [15:0] pc_r;
    logic [15:0] old_pc_r;
    logic [15:0] ir_r;
    logic [15:0] instr_count_r;
    logic        misalign_r;

    logic [15:0] jump_base_s;
    logic [15:0] jump_target_s;
    logic [15:0] next_pc_s;
    logic        branch_cond_s;
    logic        branch_taken_s;
    logic        pc_en_s;

    // Next-PC source selection; unknown selects fall back to the
    // sequential path so the PC never takes an undefined value.
    function automatic logic [15:0] sel_next_pc(
        input logic [1:0]  src,
        input logic [15:0] alu_result,
        input logic [15:0] alu_out,
        input logic [15:0] jump_target,
        input logic [15:0] reg_data
    );
        logic [15:0] res;
        case (src)
            2'd0:    res = alu_result;
            2'd1:    res = alu_out;
            2'd2:    res = jump_target;
            2'd3:    res = reg_data;
            default: res = alu_result;
        endcase
        return res;
    endfunction

    // Branch condition from the branch-type bits and the ALU equality flag
    function automatic logic eval_branch(
        input logic [1:0] kind,
        input logic       zero
    );
        logic res;
        case (kind)
            BR_EQ:   res = zero;
            BR_NE:   res = ~zero;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

    // Jump target: region bits of PC above the shifted 12-bit field,
    // truncated to the 16-bit address space by the assignment width.
    always_comb begin
        jump_base_s   = {1'b0, pc_r[15:13], ir_r[11:0]};
        jump_target_s = jump_base_s << JMP_SHIFT;
    end

    // Next-PC mux, branch resolution and PC write enable
    always_comb begin
        next_pc_s      = sel_next_pc(PCSrc, ALUResult, ALUOut, jump_target_s, RegData);
        branch_cond_s  = eval_branch(ir_r[13:12], Zero);
        branch_taken_s = isBranch & branch_cond_s;
        pc_en_s        = PCWrite | branch_taken_s;
    end

    // PC register and sticky misalignment flag; bit 0 of the PC is
    // always forced low, an odd target only raises the flag.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            pc_r       <= RESET_PC;
            misalign_r <= 1'b0;
        end else if (pc_en_s) begin
            pc_r <= {next_pc_s[15:1], 1'b0};
            if (next_pc_s[0]) begin
                misalign_r <= 1'b1;
            end else begin
                misalign_r <= misalign_r;
            end
        end else begin
            pc_r       <= pc_r;
            misalign_r <= misalign_r;
        end
    end

    // Instruction load: IR, the PC it was fetched from (pre-update value)
    // and the retired-instruction counter, which wraps naturally.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            ir_r          <= 16'h0000;
            old_pc_r      <= RESET_PC;
            instr_count_r <= 16'h0000;
        end else if (IRWrite) begin
            ir_r          <= MemData;
            old_pc_r      <= pc_r;
            instr_count_r <= instr_count_r + 16'd1;
        end else begin
            ir_r          <= ir_r;
            old_pc_r      <= old_pc_r;
            instr_count_r <= instr_count_r;
        end
    end

    assign PC          = pc_r;
    assign OldPC       = old_pc_r;
    assign IR          = ir_r;
    assign InstrCount  = instr_count_r;
    assign PCMisalign  = misalign_r;
    assign Opcode      = {2'b00, ir_r[15:12]};
    assign Rd          = ir_r[11:8];
    assign Rs          = ir_r[7:4];
    assign Rt          = ir_r[3:0];
    assign Imm         = {{8{ir_r[7]}}, ir_r[7:0]};
    assign BranchTaken = branch_taken_s;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a reference model computes the
// expected register state per edge, pushes it to a scoreboard queue and
// each test pops and compares after the edge.
module tb_fetch_unit;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        IRWrite, PCWrite, isBranch, Zero;
    logic [1:0]  PCSrc;
    logic [15:0] MemData, ALUResult, ALUOut, RegData;
    logic [5:0]  Opcode;
    logic [15:0] PC, OldPC, IR, Imm, InstrCount;
    logic [3:0]  Rd, Rs, Rt;
    logic        BranchTaken, PCMisalign;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [15:0] pc;
        logic [15:0] old_pc;
        logic [15:0] ir;
        logic [15:0] cnt;
        logic        mis;
    } exp_t;

    exp_t sb_q[$];

    logic [15:0] m_pc, m_old, m_ir, m_cnt;
    logic        m_mis;

    fetch_unit dut (
        .CLK(CLK), .Reset(Reset), .IRWrite(IRWrite), .PCWrite(PCWrite),
        .isBranch(isBranch), .PCSrc(PCSrc), .MemData(MemData),
        .ALUResult(ALUResult), .ALUOut(ALUOut), .RegData(RegData), .Zero(Zero),
        .Opcode(Opcode), .PC(PC), .OldPC(OldPC), .IR(IR), .Rd(Rd), .Rs(Rs),
        .Rt(Rt), .Imm(Imm), .BranchTaken(BranchTaken), .PCMisalign(PCMisalign),
        .InstrCount(InstrCount)
    );

    always #5 CLK = ~CLK;

    task automatic model_reset();
        m_pc  = 16'h0000;
        m_old = 16'h0000;
        m_ir  = 16'h0000;
        m_cnt = 16'h0000;
        m_mis = 1'b0;
        sb_q.delete();
    endtask

    // Apply one clock of stimulus, predict the resulting state, push it.
    task automatic drive(input logic irw, input logic pcw, input logic isb,
                         input logic [1:0] src, input logic [15:0] md,
                         input logic [15:0] alur, input logic [15:0] aluo,
                         input logic [15:0] rdat, input logic z);
        logic [15:0] mux;
        logic        taken;
        exp_t        e;
        IRWrite = irw; PCWrite = pcw; isBranch = isb; PCSrc = src;
        MemData = md; ALUResult = alur; ALUOut = aluo; RegData = rdat; Zero = z;
        taken = isb && ((m_ir[13:12] == 2'b01 && z) || (m_ir[13:12] == 2'b10 && !z));
        case (src)
            2'd0:    mux = alur;
            2'd1:    mux = aluo;
            2'd2:    mux = {m_pc[15:13], m_ir[11:0], 1'b0};
            default: mux = rdat;
        endcase
        if (irw) begin
            m_old = m_pc;
            m_ir  = md;
            m_cnt = m_cnt + 16'd1;
        end
        if (pcw || taken) begin
            m_pc = {mux[15:1], 1'b0};
            if (mux[0]) m_mis = 1'b1;
        end
        e.pc = m_pc; e.old_pc = m_old; e.ir = m_ir; e.cnt = m_cnt; e.mis = m_mis;
        sb_q.push_back(e);
        @(posedge CLK);
        #1;
        IRWrite = 1'b0; PCWrite = 1'b0; isBranch = 1'b0;
    endtask

    task automatic apply_reset();
        #3 Reset = 1'b1;
        #3 Reset = 1'b0;
        @(posedge CLK);
        #1;
        model_reset();
    endtask

    task automatic test_reset();
        exp_t e;
        n_tests++;
        if ({PC, OldPC, IR, InstrCount, PCMisalign, Opcode} !== {16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 6'd0}) begin
            n_fail++;
            $display("FAIL reset_initial: got PC=%h OldPC=%h IR=%h Cnt=%h Mis=%b Op=%h, want all zero",
                     PC, OldPC, IR, InstrCount, PCMisalign, Opcode);
        end
        drive(1'b1, 1'b1, 1'b0, 2'd0, 16'h1234, 16'h0042, 16'h0, 16'h0, 1'b0);
        e = sb_q.pop_front();
        n_tests++;
        if ({PC, OldPC, IR, InstrCount} !== {e.pc, e.old_pc, e.ir, e.cnt}) begin
            n_fail++;
            $display("FAIL reset_preload: got %h %h %h %h want %h %h %h %h",
                     PC, OldPC, IR, InstrCount, e.pc, e.old_pc, e.ir, e.cnt);
        end
        // Assert reset mid-cycle and sample before the next rising edge
        #3 Reset = 1'b1;
        #1;
        n_tests++;
        if ({PC, OldPC, IR, Opcode, InstrCount, PCMisalign} !== {16'h0, 16'h0, 16'h0, 6'd0, 16'h0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_async: got PC=%h OldPC=%h IR=%h Op=%h Cnt=%h, want zeros",
                     PC, OldPC, IR, Opcode, InstrCount);
        end
        #2 Reset = 1'b0;
        @(posedge CLK);
        #1;
        model_reset();
    endtask

    task automatic test_fetch();
        exp_t e;
        drive(1'b1, 1'b1, 1'b0, 2'd0, 16'h1A05, 16'h0002, 16'h0, 16'h0, 1'b0);
        e = sb_q.pop_front();
        n_tests++;
        if ({PC, OldPC, IR, InstrCount} !== {e.pc, e.old_pc, e.ir, e.cnt}) begin
            n_fail++;
            $display("FAIL fetch_state: got %h %h %h %h want %h %h %h %h",
                     PC, OldPC, IR, InstrCount, e.pc, e.old_pc, e.ir, e.cnt);
        end
        n_tests++;
        if ({Opcode, Rd, Rs, Rt, Imm} !== {6'd1, 4'hA, 4'h0, 4'h5, 16'h0005}) begin
            n_fail++;
            $display("FAIL fetch_decode: got Op=%h Rd=%h Rs=%h Rt=%h Imm=%h want 01 a 0 5 0005",
                     Opcode, Rd, Rs, Rt, Imm);
        end
    endtask

    task automatic test_branch();
        exp_t e;
        isBranch = 1'b0; Zero = 1'b1; #1;
        n_tests++;
        if (BranchTaken !== 1'b0) begin
            n_fail++; $display("FAIL br_no_strobe: got %b want 0", BranchTaken);
        end
        isBranch = 1'b1; Zero = 1'b1; #1;
        n_tests++;
        if (BranchTaken !== 1'b1) begin
            n_fail++; $display("FAIL br_eq_taken_comb: got %b want 1", BranchTaken);
        end
        drive(1'b0, 1'b0, 1'b1, 2'd1, 16'h0, 16'h0, 16'h0020, 16'h0, 1'b1);
        e = sb_q.pop_front();
        n_tests++;
        if (PC !== e.pc) begin
            n_fail++; $display("FAIL br_eq_taken: got PC=%h want %h", PC, e.pc);
        end
        isBranch = 1'b1; Zero = 1'b0; #1;
        n_tests++;
        if (BranchTaken !== 1'b0) begin
            n_fail++; $display("FAIL br_eq_not_taken_comb: got %b want 0", BranchTaken);
        end
        drive(1'b0, 1'b0, 1'b1, 2'd1, 16'h0, 16'h0, 16'h0040, 16'h0, 1'b0);
        e = sb_q.pop_front();
        n_tests++;
        if (PC !== e.pc) begin
            n_fail++; $display("FAIL br_eq_not_taken: got PC=%h want %h", PC, e.pc);
        end
        drive(1'b1, 1'b0, 1'b0, 2'd0, 16'h2345, 16'h0, 16'h0, 16'h0, 1'b0);
        e = sb_q.pop_front();
        isBranch = 1'b1; Zero = 1'b0; #1;
        n_tests++;
        if (BranchTaken !== 1'b1) begin
            n_fail++; $display("FAIL br_ne_taken_comb: got %b want 1", BranchTaken);
        end
        drive(1'b0, 1'b0, 1'b1, 2'd1, 16'h0, 16'h0, 16'h0064, 16'h0, 1'b0);
        e = sb_q.pop_front();
        n_tests++;
        if ({PC, OldPC, IR} !== {e.pc, e.old_pc, e.ir}) begin
            n_fail++;
            $display("FAIL br_ne_taken: got %h %h %h want %h %h %h", PC, OldPC, IR, e.pc, e.old_pc, e.ir);
        end
    endtask

    task automatic test_jump();
        exp_t e;
        drive(1'b0, 1'b1, 1'b0, 2'd0, 16'h0, 16'h4000, 16'h0, 16'h0, 1'b0);
        e = sb_q.pop_front();
        drive(1'b1, 1'b0, 1'b0, 2'd0, 16'h3123, 16'h0, 16'h0, 16'h0, 1'b0);
        e = sb_q.pop_front();
        isBranch = 1'b1; Zero = 1'b1; #1;
        n_tests++;
        if (BranchTaken !== 1'b0) begin
            n_fail++; $display("FAIL br_kind11_never: got %b want 0", BranchTaken);
        end
        drive(1'b0, 1'b1, 1'b0, 2'd2, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0);
        e = sb_q.pop_front();
        n_tests++;
        if ({PC, e.pc} !== {16'h4246, 16'h4246}) begin
            n_fail++; $display("FAIL jump_target: got PC=%h want 4246 (model %h)", PC, e.pc);
        end
        drive(1'b0, 1'b1, 1'b0, 2'd3, 16'h0, 16'h0, 16'h0, 16'h0101, 1'b0);
        e = sb_q.pop_front();
        n_tests++;
        if ({PC, PCMisalign} !== {e.pc, e.mis}) begin
            n_fail++; $display("FAIL jr_misalign: got PC=%h Mis=%b want %h %b", PC, PCMisalign, e.pc, e.mis);
        end
        drive(1'b0, 1'b1, 1'b0, 2'd0, 16'h0, 16'h0200, 16'h0, 16'h0, 1'b0);
        e = sb_q.pop_front();
        n_tests++;
        if ({PC, PCMisalign} !== {e.pc, e.mis}) begin
            n_fail++; $display("FAIL misalign_sticky: got PC=%h Mis=%b want %h %b", PC, PCMisalign, e.pc, e.mis);
        end
        apply_reset();
        n_tests++;
        if (PCMisalign !== 1'b0) begin
            n_fail++; $display("FAIL misalign_clear: got %b want 0", PCMisalign);
        end
    endtask

    task automatic test_hold();
        exp_t e;
        drive(1'b1, 1'b1, 1'b0, 2'd0, 16'hBEEF, 16'h0010, 16'h0, 16'h0, 1'b0);
        e = sb_q.pop_front();
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, 1'b0, 2'($urandom_range(3, 0)), 16'($urandom),
                  16'($urandom), 16'($urandom), 16'($urandom), 1'($urandom));
            e = sb_q.pop_front();
            n_tests++;
            if ({PC, OldPC, IR, InstrCount} !== {e.pc, e.old_pc, e.ir, e.cnt}) begin
                n_fail++;
                $display("FAIL hold_%0d: got %h %h %h %h want %h %h %h %h", i,
                         PC, OldPC, IR, InstrCount, e.pc, e.old_pc, e.ir, e.cnt);
            end
        end
    endtask

    task automatic test_signext();
        logic [15:0] words [3] = '{16'h70F0, 16'h0080, 16'h007F};
        logic [15:0] imms  [3] = '{16'hFFF0, 16'hFF80, 16'h007F};
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b0, 2'd0, words[i], 16'h0, 16'h0, 16'h0, 1'b0);
            e = sb_q.pop_front();
            n_tests++;
            if ({Imm, Opcode, Rd, Rs, Rt} !== {imms[i], 2'b00, words[i][15:12], words[i][11:8],
                                             words[i][7:4], words[i][3:0]}) begin
                n_fail++;
                $display("FAIL signext_%0d: got Imm=%h Op=%h want Imm=%h", i, Imm, Opcode, imms[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 1'b0, 2'd0, 16'($urandom), m_pc + 16'd2, 16'h0, 16'h0, 1'b0);
            e = sb_q.pop_front();
            n_tests++;
            if ({PC, OldPC, IR, InstrCount} !== {e.pc, e.old_pc, e.ir, e.cnt}) begin
                n_fail++;
                $display("FAIL b2b_%0d: got %h %h %h %h want %h %h %h %h", i,
                         PC, OldPC, IR, InstrCount, e.pc, e.old_pc, e.ir, e.cnt);
            end
        end
    endtask

    task automatic test_wrap();
        exp_t e;
        apply_reset();
        for (int i = 0; i < 65536; i++) begin
            drive(1'b1, 1'b0, 1'b0, 2'd0, 16'(i), 16'h0, 16'h0, 16'h0, 1'b0);
            e = sb_q.pop_front();
            if (i == 65534) begin
                n_tests++;
                if ({InstrCount, e.cnt} !== {16'hFFFF, 16'hFFFF}) begin
                    n_fail++; $display("FAIL count_max: got %h want ffff", InstrCount);
                end
            end
            if (i == 65535) begin
                n_tests++;
                if ({InstrCount, IR} !== {e.cnt, e.ir} || InstrCount !== 16'h0000) begin
                    n_fail++; $display("FAIL count_wrap: got Cnt=%h IR=%h want 0000 %h", InstrCount, IR, e.ir);
                end
            end
        end
    endtask

    initial begin
        Reset = 1'b1;
        IRWrite = 1'b0; PCWrite = 1'b0; isBranch = 1'b0; Zero = 1'b0;
        PCSrc = 2'd0; MemData = 16'h0; ALUResult = 16'h0; ALUOut = 16'h0; RegData = 16'h0;
        model_reset();
        #12 Reset = 1'b0;
        @(posedge CLK);
        #1;
        test_reset();
        test_fetch();
        test_branch();
        test_jump();
        test_hold();
        test_signext();
        test_back_to_back();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
